// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter: merges ALU, load and base writebacks onto two write ports,
// queueing overflow in an age-ordered FIFO. Define RF_WB_FORWARD_EN to add queued-data forwarding.
module rf_wb_arbiter #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        a_valid,
    input  logic [3:0]  a_addr,
    input  logic [31:0] a_data,
    input  logic        m_valid,
    input  logic [3:0]  m_addr,
    input  logic [31:0] m_data,
    input  logic        b_valid,
    input  logic [3:0]  b_addr,
    input  logic [31:0] b_data,
`ifdef RF_WB_FORWARD_EN
    input  logic [3:0]  fwd_ra,
    output logic        fwd_hit,
    output logic [31:0] fwd_data,
`endif
    output logic        we1,
    output logic        we2,
    output logic [3:0]  wa1,
    output logic [3:0]  wa2,
    output logic [31:0] wd1,
    output logic [31:0] wd2,
    output logic        stall,
    output logic [14:0] busy,
    output logic        pc_err,
    output logic        ovf_err
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [3:0]    r_fifo_addr [DEPTH];
    logic [31:0]   r_fifo_data [DEPTH];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;

    logic          r_we1, r_we2, r_pc_err, r_ovf_err;
    logic [3:0]    r_wa1, r_wa2;
    logic [31:0]   r_wd1, r_wd2;

    logic [2:0]    w_req_valid;
    logic [3:0]    w_req_addr [3];
    logic [31:0]   w_req_data [3];
    logic [3:0]    w_new_addr [3];
    logic [31:0]   w_new_data [3];
    logic [1:0]    w_new_n;
    logic          w_pc_hit;

    logic [3:0]    w_head0_addr, w_head1_addr;
    logic [31:0]   w_head0_data, w_head1_data;

    logic          w_iss0_v, w_iss1_v;
    logic [3:0]    w_iss0_addr, w_iss1_addr;
    logic [31:0]   w_iss0_data, w_iss1_data;
    logic [1:0]    w_n_deq, w_skip, w_want, w_n_enq;
    logic [CW-1:0] w_free;
    logic          w_ovf;
    logic [3:0]    w_enq_addr [3];
    logic [31:0]   w_enq_data [3];

    always_comb begin
        w_req_valid   = {b_valid, m_valid, a_valid};
        w_req_addr[0] = a_addr;
        w_req_addr[1] = m_addr;
        w_req_addr[2] = b_addr;
        w_req_data[0] = a_data;
        w_req_data[1] = m_data;
        w_req_data[2] = b_data;
    end

    // Pack the surviving new requests (r15 targets removed) into age order a, m, b.
    always_comb begin
        w_new_n  = 2'd0;
        w_pc_hit = 1'b0;
        for (int i = 0; i < 3; i++) begin
            w_new_addr[i] = 4'h0;
            w_new_data[i] = 32'h0;
        end
        for (int i = 0; i < 3; i++) begin
            if (w_req_valid[i]) begin
                if (w_req_addr[i] == 4'hF) begin
                    w_pc_hit = 1'b1;
                end else begin
                    w_new_addr[w_new_n] = w_req_addr[i];
                    w_new_data[w_new_n] = w_req_data[i];
                    w_new_n = w_new_n + 2'd1;
                end
            end
        end
    end

    always_comb begin
        w_head0_addr = r_fifo_addr[r_rd_ptr];
        w_head0_data = r_fifo_data[r_rd_ptr];
        w_head1_addr = r_fifo_addr[r_rd_ptr + PW'(1)];
        w_head1_data = r_fifo_data[r_rd_ptr + PW'(1)];
    end

    // In-order issue: the second slot is used only when its address differs from the first.
    always_comb begin
        w_iss0_v    = 1'b0;
        w_iss1_v    = 1'b0;
        w_iss0_addr = 4'h0;
        w_iss0_data = 32'h0;
        w_iss1_addr = 4'h0;
        w_iss1_data = 32'h0;
        w_n_deq     = 2'd0;
        w_skip      = 2'd0;
        if (r_count != '0) begin
            w_iss0_v    = 1'b1;
            w_iss0_addr = w_head0_addr;
            w_iss0_data = w_head0_data;
            w_n_deq     = 2'd1;
            if (r_count >= CW'(2) && w_head1_addr != w_head0_addr) begin
                w_iss1_v    = 1'b1;
                w_iss1_addr = w_head1_addr;
                w_iss1_data = w_head1_data;
                w_n_deq     = 2'd2;
            end
        end else if (w_new_n >= 2'd1) begin
            w_iss0_v    = 1'b1;
            w_iss0_addr = w_new_addr[0];
            w_iss0_data = w_new_data[0];
            w_skip      = 2'd1;
            if (w_new_n >= 2'd2 && w_new_addr[1] != w_new_addr[0]) begin
                w_iss1_v    = 1'b1;
                w_iss1_addr = w_new_addr[1];
                w_iss1_data = w_new_data[1];
                w_skip      = 2'd2;
            end
        end
    end

    // Whatever was not issued directly is queued; the youngest excess is dropped when space runs out.
    always_comb begin
        w_want = w_new_n - w_skip;
        w_free = CW'(DEPTH) - r_count + CW'(w_n_deq);
        w_ovf  = 1'b0;
        if (CW'(w_want) > w_free) begin
            w_n_enq = w_free[1:0];
            w_ovf   = 1'b1;
        end else begin
            w_n_enq = w_want;
        end
        for (int j = 0; j < 3; j++) begin
            w_enq_addr[j] = 4'h0;
            w_enq_data[j] = 32'h0;
            if (j + int'(w_skip) < 3) begin
                w_enq_addr[j] = w_new_addr[j + int'(w_skip)];
                w_enq_data[j] = w_new_data[j + int'(w_skip)];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_we1     <= 1'b0;
            r_we2     <= 1'b0;
            r_wa1     <= 4'h0;
            r_wa2     <= 4'h0;
            r_wd1     <= 32'h0;
            r_wd2     <= 32'h0;
            r_rd_ptr  <= '0;
            r_wr_ptr  <= '0;
            r_count   <= '0;
            r_pc_err  <= 1'b0;
            r_ovf_err <= 1'b0;
        end else begin
            r_we1 <= w_iss0_v;
            r_we2 <= w_iss1_v;
            if (w_iss0_v) begin
                r_wa1 <= w_iss0_addr;
                r_wd1 <= w_iss0_data;
            end
            if (w_iss1_v) begin
                r_wa2 <= w_iss1_addr;
                r_wd2 <= w_iss1_data;
            end
            r_rd_ptr <= r_rd_ptr + PW'(w_n_deq);
            r_wr_ptr <= r_wr_ptr + PW'(w_n_enq);
            r_count  <= r_count - CW'(w_n_deq) + CW'(w_n_enq);
            if (w_pc_hit) r_pc_err <= 1'b1;
            if (w_ovf)    r_ovf_err <= 1'b1;
        end
    end

    // Entry storage needs no reset: occupancy alone decides which entries are live.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (k < int'(w_n_enq)) begin
                r_fifo_addr[r_wr_ptr + PW'(k)] <= w_enq_addr[k];
                r_fifo_data[r_wr_ptr + PW'(k)] <= w_enq_data[k];
            end
        end
    end

    always_comb begin
        busy = 15'h0;
        for (int j = 0; j < DEPTH; j++) begin
            if (CW'(j) < r_count && r_fifo_addr[r_rd_ptr + PW'(j)] != 4'hF) begin
                busy[r_fifo_addr[r_rd_ptr + PW'(j)]] = 1'b1;
            end
        end
    end

`ifdef RF_WB_FORWARD_EN
    // Scanning oldest to youngest lets the youngest match win.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = 32'h0;
        for (int j = 0; j < DEPTH; j++) begin
            if (CW'(j) < r_count && fwd_ra != 4'hF &&
                r_fifo_addr[r_rd_ptr + PW'(j)] == fwd_ra) begin
                fwd_hit  = 1'b1;
                fwd_data = r_fifo_data[r_rd_ptr + PW'(j)];
            end
        end
    end
`endif

    assign stall   = (r_count > CW'(DEPTH - 3));
    assign we1     = r_we1;
    assign we2     = r_we2;
    assign wa1     = r_wa1;
    assign wa2     = r_wa2;
    assign wd1     = r_wd1;
    assign wd2     = r_wd2;
    assign pc_err  = r_pc_err;
    assign ovf_err = r_ovf_err;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: bypass, queueing, collision, r15 drop, full pressure, reset, forwarding.
module tb_rf_wb_arbiter;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        a_valid, m_valid, b_valid;
    logic [3:0]  a_addr, m_addr, b_addr;
    logic [31:0] a_data, m_data, b_data;
    logic        we1, we2, stall, pc_err, ovf_err;
    logic [3:0]  wa1, wa2;
    logic [31:0] wd1, wd2;
    logic [14:0] busy;
`ifdef RF_WB_FORWARD_EN
    logic [3:0]  fwd_ra;
    logic        fwd_hit;
    logic [31:0] fwd_data;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int txn = 0;

    always #5 clk = ~clk;

    rf_wb_arbiter #(.DEPTH(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data),
        .m_valid(m_valid), .m_addr(m_addr), .m_data(m_data),
        .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data),
`ifdef RF_WB_FORWARD_EN
        .fwd_ra(fwd_ra), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
`endif
        .we1(we1), .we2(we2), .wa1(wa1), .wa2(wa2), .wd1(wd1), .wd2(wd2),
        .stall(stall), .busy(busy), .pc_err(pc_err), .ovf_err(ovf_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        txn++;
        $display("txn %0d: we1=%0b wa1=%0d wd1=0x%0h we2=%0b wa2=%0d wd2=0x%0h busy=0x%0h stall=%0b pc=%0b ovf=%0b",
                 txn, we1, wa1, wd1, we2, wa2, wd2, busy, stall, pc_err, ovf_err);
    endtask

    task automatic clr_req();
        a_valid = 0; m_valid = 0; b_valid = 0;
        a_addr = 0; m_addr = 0; b_addr = 0;
        a_data = 0; m_data = 0; b_data = 0;
    endtask

    task automatic set_req(input int slot, input logic [3:0] addr, input logic [31:0] data);
        case (slot)
            0: begin a_valid = 1; a_addr = addr; a_data = data; end
            1: begin m_valid = 1; m_addr = addr; m_data = data; end
            default: begin b_valid = 1; b_addr = addr; b_data = data; end
        endcase
    endtask

    task automatic check_ports(input string tag, input logic e1, input logic [3:0] a1, input logic [31:0] d1,
                               input logic e2, input logic [3:0] a2, input logic [31:0] d2);
        check({tag, ".we1"}, 32'(we1), 32'(e1));
        if (e1) begin
            check({tag, ".wa1"}, 32'(wa1), 32'(a1));
            check({tag, ".wd1"}, wd1, d1);
        end
        check({tag, ".we2"}, 32'(we2), 32'(e2));
        if (e2) begin
            check({tag, ".wa2"}, 32'(wa2), 32'(a2));
            check({tag, ".wd2"}, wd2, d2);
        end
    endtask

    int exp_cnt [13] = '{1, 3, 4, 5, 6, 7, 8, 8, 6, 4, 2, 0, 0};

    initial begin
        reset_n = 0;
        clr_req();
`ifdef RF_WB_FORWARD_EN
        fwd_ra = 0;
`endif
        tick();
        tick();
        check_ports("rst", 0, 0, 0, 0, 0, 0);
        check("rst.wa1", 32'(wa1), 0);
        check("rst.wd2", wd2, 0);
        check("rst.busy", 32'(busy), 0);
        check("rst.stall", 32'(stall), 0);
        check("rst.pc", 32'(pc_err), 0);
        check("rst.ovf", 32'(ovf_err), 0);
        reset_n = 1;
        tick();
        check_ports("idle", 0, 0, 0, 0, 0, 0);

        // Bypass of two requests
        set_req(0, 4'd1, 32'h11);
        set_req(1, 4'd2, 32'h22);
        tick();
        clr_req();
        check_ports("byp", 1, 4'd1, 32'h11, 1, 4'd2, 32'h22);
        check("byp.busy", 32'(busy), 0);
        tick();
        check_ports("byp.after", 0, 0, 0, 0, 0, 0);
        check("byp.hold_wa1", 32'(wa1), 1);
        check("byp.hold_wd2", wd2, 32'h22);

        // Third request goes to the queue
        set_req(0, 4'd1, 32'h1);
        set_req(1, 4'd2, 32'h2);
        set_req(2, 4'd3, 32'h3);
        tick();
        clr_req();
        check_ports("q3.c1", 1, 4'd1, 32'h1, 1, 4'd2, 32'h2);
        check("q3.busy1", 32'(busy), 32'h8);
        tick();
        check_ports("q3.c2", 1, 4'd3, 32'h3, 0, 0, 0);
        check("q3.busy2", 32'(busy), 0);

        // Same-address collision
        set_req(0, 4'd5, 32'hA);
        set_req(1, 4'd5, 32'hB);
        tick();
        clr_req();
        check_ports("col.c1", 1, 4'd5, 32'hA, 0, 0, 0);
        check("col.busy", 32'(busy), 32'h20);
        tick();
        check_ports("col.c2", 1, 4'd5, 32'hB, 0, 0, 0);
        check("col.busy2", 32'(busy), 0);

        // r15 write is dropped
        set_req(2, 4'hF, 32'hDEAD);
        tick();
        clr_req();
        check_ports("pc.c1", 0, 0, 0, 0, 0, 0);
        check("pc.err", 32'(pc_err), 1);
        check("pc.busy", 32'(busy), 0);
        tick();
        check_ports("pc.c2", 0, 0, 0, 0, 0, 0);
        check("pc.sticky", 32'(pc_err), 1);
        check("pc.ovf", 32'(ovf_err), 0);

        // Full pressure: request s targets r((s+1)%15) with data 0x1000+s
        for (int n = 1; n <= 13; n++) begin
            int s1, s2;
            logic e1, e2;
            clr_req();
            if (n <= 8) begin
                for (int k = 0; k < 3; k++) begin
                    int s;
                    s = 3 * (n - 1) + k;
                    set_req(k, 4'((s + 1) % 15), 32'h1000 + 32'(s));
                end
            end
            tick();
            e1 = 1; e2 = 1;
            if (n == 1) begin s1 = 0; s2 = 1; end
            else if (n == 2) begin s1 = 2; s2 = 0; e2 = 0; end
            else if (n <= 12) begin s1 = 2 * n - 3; s2 = 2 * n - 2; end
            else begin s1 = 0; s2 = 0; e1 = 0; e2 = 0; end
            check_ports($sformatf("pres%0d", n), e1, 4'((s1 + 1) % 15), 32'h1000 + 32'(s1),
                        e2, 4'((s2 + 1) % 15), 32'h1000 + 32'(s2));
            check($sformatf("pres%0d.stall", n), 32'(stall), 32'(exp_cnt[n-1] >= 6));
            check($sformatf("pres%0d.ovf", n), 32'(ovf_err), 32'(n >= 8));
        end
        clr_req();

        // Queue four entries including r7 twice, then reset mid-operation
        set_req(0, 4'd1, 32'h31);
        set_req(1, 4'd2, 32'h32);
        set_req(2, 4'd3, 32'h33);
        tick();
        clr_req();
        set_req(0, 4'd7, 32'h1);
        set_req(1, 4'd5, 32'h55);
        set_req(2, 4'd7, 32'h2);
        tick();
        clr_req();
        check_ports("fw.c2", 1, 4'd3, 32'h33, 0, 0, 0);
        check("fw.busy2", 32'(busy), 32'hA0);
`ifdef RF_WB_FORWARD_EN
        fwd_ra = 4'd7; #1;
        check("fw.hit7", 32'(fwd_hit), 1);
        check("fw.data7", fwd_data, 32'h2);
        fwd_ra = 4'd6; #1;
        check("fw.hit6", 32'(fwd_hit), 0);
        check("fw.data6", fwd_data, 0);
        fwd_ra = 4'hF; #1;
        check("fw.hitF", 32'(fwd_hit), 0);
        fwd_ra = 4'd7;
`endif
        set_req(0, 4'd8, 32'h88);
        set_req(1, 4'd9, 32'h99);
        set_req(2, 4'd10, 32'hAA);
        tick();
        clr_req();
        check_ports("fw.c3", 1, 4'd7, 32'h1, 1, 4'd5, 32'h55);
        check("fw.busy3", 32'(busy), 32'h780);
        check("fw.stall3", 32'(stall), 0);
`ifdef RF_WB_FORWARD_EN
        check("fw.hit7b", 32'(fwd_hit), 1);
        check("fw.data7b", fwd_data, 32'h2);
`endif
        reset_n = 0;
        #1;
        check_ports("mrst", 0, 0, 0, 0, 0, 0);
        check("mrst.wa1", 32'(wa1), 0);
        check("mrst.wa2", 32'(wa2), 0);
        check("mrst.wd1", wd1, 0);
        check("mrst.wd2", wd2, 0);
        check("mrst.busy", 32'(busy), 0);
        check("mrst.stall", 32'(stall), 0);
        check("mrst.pc", 32'(pc_err), 0);
        check("mrst.ovf", 32'(ovf_err), 0);
`ifdef RF_WB_FORWARD_EN
        check("mrst.fwd", 32'(fwd_hit), 0);
`endif
        tick();
        tick();
        reset_n = 1;
        tick();
        check_ports("post", 0, 0, 0, 0, 0, 0);
        check("post.busy", 32'(busy), 0);
        set_req(0, 4'd4, 32'h44);
        tick();
        clr_req();
        check_ports("post.byp", 1, 4'd4, 32'h44, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
